// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction fetch stage with a DEPTH-entry fetch queue.
// Issues sequential word-aligned PC requests to an in-order, variable-latency
// instruction memory, buffers the returned words with their PCs, and hands
// them to decode over valid/ready. A redirect flushes the queue; responses
// still in flight for flushed requests are counted and silently discarded.
//
// Ports:
//   clk, reset                 clock (rising edge), async active-high reset
//   imem_req_valid/ready/addr  fetch request channel
//   imem_rsp_valid/data        in-order response channel, no backpressure
//   redirect_valid/pc          branch/flush redirect (pc bits [1:0] ignored)
//   out_valid/ready/pc/instr   decode handshake, head of queue
//   perf_fetch_cnt             decode handshakes      (IF_FETCH_PERF_EN only)
//   perf_drop_cnt              discarded responses    (IF_FETCH_PERF_EN only)
//
// Build option: define IF_FETCH_PERF_EN to add the two performance counters.
module if_fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_drop_cnt
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  // Queue storage; entries between head and fill are filled, fill to tail are in flight
  logic [XLEN-1:0]  pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];

  logic [PTR_W-1:0] head_ptr, tail_ptr, fill_ptr;
  logic [CNT_W-1:0] alloc_cnt;   // allocated entries (in flight + buffered)
  logic [CNT_W-1:0] unfill_cnt;  // allocated entries still awaiting a response
  logic [CNT_W-1:0] drop_cnt;    // stale responses still to be discarded
  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  hold_pc;
  logic [31:0]      hold_instr;

  logic             head_filled;
  logic             do_alloc, do_fill, do_pop, rsp_drop;
  logic [CNT_W-1:0] redir_drop;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

  // Handshake decode; reset gates the request so it is low while reset is held
  always_comb begin
    head_filled    = (alloc_cnt != unfill_cnt);
    imem_req_valid = !reset && (alloc_cnt < CNT_W'(DEPTH)) && !redirect_valid;
    imem_req_addr  = fetch_pc;
    out_valid      = head_filled && !redirect_valid;
    out_pc         = head_filled ? pc_mem[head_ptr]    : hold_pc;
    out_instr      = head_filled ? instr_mem[head_ptr] : hold_instr;
    do_alloc       = imem_req_valid && imem_req_ready;
    do_pop         = out_valid && out_ready;
    rsp_drop       = imem_rsp_valid && (drop_cnt != '0);
    do_fill        = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
    // Every outstanding response becomes stale; one arriving now is consumed now
    redir_drop     = drop_cnt + unfill_cnt - CNT_W'(imem_rsp_valid);
  end

  // Payload writes; contents are only observed once the matching count says so
  always_ff @(posedge clk) begin
    if (do_alloc) pc_mem[tail_ptr]    <= fetch_pc;
    if (do_fill)  instr_mem[fill_ptr] <= imem_rsp_data;
  end

  // Queue control and fetch PC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc   <= RESET_PC;
      head_ptr   <= '0;
      tail_ptr   <= '0;
      fill_ptr   <= '0;
      alloc_cnt  <= '0;
      unfill_cnt <= '0;
      drop_cnt   <= '0;
    end else if (redirect_valid) begin
      fetch_pc   <= {redirect_pc[XLEN-1:2], 2'b00};
      head_ptr   <= '0;
      tail_ptr   <= '0;
      fill_ptr   <= '0;
      alloc_cnt  <= '0;
      unfill_cnt <= '0;
      drop_cnt   <= redir_drop;
    end else begin
      if (do_alloc) begin
        tail_ptr <= tail_ptr + PTR_W'(1);
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      if (do_fill) fill_ptr <= fill_ptr + PTR_W'(1);
      if (do_pop)  head_ptr <= head_ptr + PTR_W'(1);
      if (rsp_drop) drop_cnt <= drop_cnt - CNT_W'(1);
      alloc_cnt  <= alloc_cnt + CNT_W'(do_alloc) - CNT_W'(do_pop);
      unfill_cnt <= unfill_cnt + CNT_W'(do_alloc) - CNT_W'(do_fill);
    end
  end

  // Last presented head, so the output holds while the queue is empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_pc    <= '0;
      hold_instr <= '0;
    end else if (head_filled) begin
      hold_pc    <= pc_mem[head_ptr];
      hold_instr <= instr_mem[head_ptr];
    end
  end

`ifdef IF_FETCH_PERF_EN
  // Free-running event counters; a response arriving during a redirect is discarded
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      if (do_pop) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (imem_rsp_valid && (drop_cnt != '0 || redirect_valid))
        perf_drop_cnt <= perf_drop_cnt + 32'd1;
    end
  end
`endif

endmodule
